// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioning: per-pin synchronizer, stable-count glitch filter
// and single-cycle edge pulses derived from the filtered level.
module gpio_in_conditioner #(
   parameter int GpioCount  = 32,
   parameter int SyncStages = 2,
   parameter int FiltCntW   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [GpioCount-1:0] pad_gpio_i,
   input  logic [GpioCount-1:0] filt_en_i,
   input  logic [FiltCntW-1:0]  thresh_i,
   output logic [GpioCount-1:0] gpio_o,
   output logic [GpioCount-1:0] rise_o,
   output logic [GpioCount-1:0] fall_o
);

   logic [SyncStages-1:0][GpioCount-1:0] sync_q;
   logic [SyncStages-1:0][GpioCount-1:0] sync_d;
   logic [GpioCount-1:0]                 sync_out;
   logic [GpioCount-1:0]                 stable_vec;
   logic [GpioCount-1:0]                 prev_q;
   logic [FiltCntW-1:0]                  thresh_eff;

   // Only stage 0 ever sees the asynchronous pad value.
   assign sync_d   = {sync_q[SyncStages-2:0], pad_gpio_i};
   assign sync_out = sync_q[SyncStages-1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign thresh_eff = (thresh_i == '0) ? FiltCntW'(1) : thresh_i;

   generate
      for (genvar gi = 0; gi < GpioCount; gi++) begin : g_pin
         logic [FiltCntW-1:0] cnt_q;
         logic [FiltCntW-1:0] cnt_d;
         logic [FiltCntW:0]   cnt_inc;
         logic                stable_q;
         logic                stable_d;

         // cnt counts consecutive samples that disagree with the accepted level.
         always_comb begin
            cnt_inc  = {1'b0, cnt_q} + (FiltCntW+1)'(1);
            stable_d = stable_q;
            cnt_d    = '0;
            if (!filt_en_i[gi]) begin
               stable_d = sync_out[gi];
            end else if (sync_out[gi] != stable_q) begin
               if (cnt_inc >= {1'b0, thresh_eff}) begin
                  stable_d = sync_out[gi];
               end else begin
                  cnt_d = cnt_inc[FiltCntW-1:0];
               end
            end
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               cnt_q    <= '0;
               stable_q <= 1'b0;
            end else begin
               cnt_q    <= cnt_d;
               stable_q <= stable_d;
            end
         end

         assign stable_vec[gi] = stable_q;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q <= '0;
      end else begin
         prev_q <= stable_vec;
      end
   end

   // Both operands are flops, so the pulses cannot glitch; prev resets with
   // the level, so reset release alone never produces a pulse.
   assign gpio_o = stable_vec;
   assign rise_o = stable_vec & ~prev_q;
   assign fall_o = ~stable_vec & prev_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner: directed vector table,
// hand sequences for mid-count corner cases, and a randomized model comparison.
module tb_gpio_in_conditioner;

   localparam int G = 32;
   localparam int S = 2;
   localparam int W = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [G-1:0]  pad_gpio_i;
   logic [G-1:0]  filt_en_i;
   logic [W-1:0]  thresh_i;
   logic [G-1:0]  gpio_o;
   logic [G-1:0]  rise_o;
   logic [G-1:0]  fall_o;

   int total = 0;
   int bad   = 0;

   gpio_in_conditioner #(.GpioCount(G), .SyncStages(S), .FiltCntW(W)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .pad_gpio_i (pad_gpio_i),
      .filt_en_i  (filt_en_i),
      .thresh_i   (thresh_i),
      .gpio_o     (gpio_o),
      .rise_o     (rise_o),
      .fall_o     (fall_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int pin;
      int thr;
      bit en;
      int pulse;
      bit acc;
      int lat;
   } vec_t;

   vec_t vecs [8];

   // Reference model state: pad delay line, filtered-sample history, accepted level.
   logic [G-1:0] m_pd [S];
   logic [G-1:0] m_fh [16];
   logic [G-1:0] m_stable;
   logic [G-1:0] m_rise;
   logic [G-1:0] m_fall;

   task automatic chk(input string name, input logic [G-1:0] act, input logic [G-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni     = 1'b0;
      pad_gpio_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < S; i++) m_pd[i] = '0;
      for (int j = 0; j < 16; j++) m_fh[j] = '0;
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
   endtask

   // A pin accepts the opposite level once the most recent run of samples
   // differing from the accepted level is at least T long; bypass copies the sample.
   task automatic model_edge();
      logic [G-1:0] f;
      logic [G-1:0] nxt;
      int           teff;
      int           run;
      f = m_pd[S-1];
      for (int i = S-1; i > 0; i--) m_pd[i] = m_pd[i-1];
      m_pd[0] = pad_gpio_i;
      for (int j = 15; j > 0; j--) m_fh[j] = m_fh[j-1];
      m_fh[0] = f;
      teff = (thresh_i == 0) ? 1 : int'(thresh_i);
      nxt  = m_stable;
      for (int p = 0; p < G; p++) begin
         if (!filt_en_i[p]) begin
            nxt[p] = f[p];
         end else begin
            run = 0;
            while (run < 16 && m_fh[run][p] != m_stable[p]) run++;
            if (run >= teff) nxt[p] = ~m_stable[p];
         end
      end
      m_rise   = nxt & ~m_stable;
      m_fall   = ~nxt & m_stable;
      m_stable = nxt;
   endtask

   initial begin
      logic [G-1:0] mask;
      int rc, fc, rise_e, fall_e;
      bit other, both;

      rst_ni     = 1'b0;
      pad_gpio_i = '0;
      filt_en_i  = '0;
      thresh_i   = '0;

      vecs[0] = '{0,  1,  1'b0, 5,  1'b1, 3};
      vecs[1] = '{3,  5,  1'b1, 4,  1'b0, 0};
      vecs[2] = '{3,  5,  1'b1, 10, 1'b1, 7};
      vecs[3] = '{7,  0,  1'b1, 1,  1'b1, 3};
      vecs[4] = '{31, 15, 1'b1, 14, 1'b0, 0};
      vecs[5] = '{31, 15, 1'b1, 15, 1'b1, 17};
      vecs[6] = '{12, 2,  1'b1, 2,  1'b1, 4};
      vecs[7] = '{12, 2,  1'b1, 1,  1'b0, 0};

      do_reset();
      #1;
      chk("reset_gpio", gpio_o, '0);
      chk("reset_rise", rise_o, '0);
      chk("reset_fall", fall_o, '0);

      // Directed single-pin pulses.
      for (int v = 0; v < 8; v++) begin
         thresh_i  = W'(vecs[v].thr);
         filt_en_i = vecs[v].en ? '1 : '0;
         do_reset();
         rc = 0; fc = 0; rise_e = -1; fall_e = -1; other = 0; both = 0;
         for (int e = 1; e <= 60; e++) begin
            pad_gpio_i = '0;
            pad_gpio_i[vecs[v].pin] = (e <= vecs[v].pulse);
            tick();
            if (rise_o[vecs[v].pin]) begin rc++; rise_e = e; end
            if (fall_o[vecs[v].pin]) begin fc++; fall_e = e; end
            if (rise_o[vecs[v].pin] && fall_o[vecs[v].pin]) both = 1;
            mask = '1;
            mask[vecs[v].pin] = 1'b0;
            if (((gpio_o | rise_o | fall_o) & mask) != '0) other = 1;
         end
         $display("vec %0d pin=%0d thr=%0d en=%0d pulse=%0d rise_at=%0d fall_at=%0d",
                  v, vecs[v].pin, vecs[v].thr, vecs[v].en, vecs[v].pulse, rise_e, fall_e);
         chk($sformatf("vec%0d_rise_cnt", v), rc, vecs[v].acc ? 1 : 0);
         chk($sformatf("vec%0d_fall_cnt", v), fc, vecs[v].acc ? 1 : 0);
         chk($sformatf("vec%0d_both", v), both, 0);
         chk($sformatf("vec%0d_other_pins", v), other, 0);
         if (vecs[v].acc) begin
            chk($sformatf("vec%0d_rise_edge", v), rise_e, vecs[v].lat);
            chk($sformatf("vec%0d_fall_edge", v), fall_e, vecs[v].pulse + vecs[v].lat);
         end
      end

      // Threshold lowered from 10 to 2 while the count sits at 4.
      thresh_i  = 4'd10;
      filt_en_i = '1;
      do_reset();
      pad_gpio_i = 32'h0000_0020;
      repeat (6) tick();
      chk("thr_drop_pre_gpio", gpio_o, '0);
      thresh_i = 4'd2;
      tick();
      chk("thr_drop_gpio", gpio_o, 32'h0000_0020);
      chk("thr_drop_rise", rise_o, 32'h0000_0020);
      $display("seq thr_drop gpio=%h rise=%h", gpio_o, rise_o);

      // Filter disabled mid-count, then re-enabled counting from zero.
      thresh_i  = 4'd10;
      filt_en_i = '1;
      do_reset();
      pad_gpio_i = 32'h0000_0200;
      repeat (5) tick();
      chk("en_off_pre_gpio", gpio_o, '0);
      filt_en_i[9] = 1'b0;
      tick();
      chk("en_off_gpio", gpio_o, 32'h0000_0200);
      chk("en_off_rise", rise_o, 32'h0000_0200);
      filt_en_i  = '1;
      pad_gpio_i = '0;
      repeat (11) tick();
      chk("en_on_hold_gpio", gpio_o, 32'h0000_0200);
      tick();
      chk("en_on_fall_gpio", gpio_o, '0);
      chk("en_on_fall_pulse", fall_o, 32'h0000_0200);
      $display("seq en_toggle gpio=%h fall=%h", gpio_o, fall_o);

      // Reset asserted mid-count with all pins active.
      thresh_i  = 4'd5;
      filt_en_i = '1;
      do_reset();
      pad_gpio_i = '1;
      repeat (9) tick();
      chk("rst_pre_gpio", gpio_o, '1);
      pad_gpio_i = '0;
      repeat (4) tick();
      chk("rst_midcount_gpio", gpio_o, '1);
      rst_ni = 1'b0;
      #1;
      chk("rst_async_gpio", gpio_o, '0);
      chk("rst_async_rise", rise_o, '0);
      chk("rst_async_fall", fall_o, '0);
      pad_gpio_i = '1;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("rst_quiet_%0d", k), gpio_o | rise_o | fall_o, '0);
      end
      tick();
      chk("rst_reaccept_gpio", gpio_o, '1);
      chk("rst_reaccept_rise", rise_o, '1);
      chk("rst_reaccept_fall", fall_o, '0);
      $display("seq reset_midcount gpio=%h rise=%h", gpio_o, rise_o);

      // Randomized traffic against the reference model.
      thresh_i  = W'($urandom_range(15));
      filt_en_i = $urandom;
      do_reset();
      model_clear();
      for (int c = 0; c < 1500; c++) begin
         if (c % 2 == 0) mask = $urandom & $urandom & $urandom;
         else            mask = $urandom & $urandom & $urandom & $urandom;
         pad_gpio_i = pad_gpio_i ^ mask;
         if ($urandom_range(49) == 0) thresh_i  = W'($urandom_range(15));
         if ($urandom_range(59) == 0) filt_en_i = $urandom;
         @(posedge clk_i);
         model_edge();
         #1;
         chk($sformatf("rnd%0d_gpio", c), gpio_o, m_stable);
         chk($sformatf("rnd%0d_rise", c), rise_o, m_rise);
         chk($sformatf("rnd%0d_fall", c), fall_o, m_fall);
      end
      $display("random phase complete: 1500 cycles");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
